// File: rtl/dr_sync_sink.sv
// dr_sync_sink: dual-rail 4-phase link sink with completion synchronizers; optional sticky err_o under DR_SINK_ERR_EN
module dr_sync_sink #(
    parameter int unsigned WIDTH       = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [WIDTH-1:0][1:0] in,
    output logic                  ack_o,
    output logic [WIDTH-1:0]      data_o,
    output logic                  valid_o,
    input  logic                  ready_i
`ifdef DR_SINK_ERR_EN
    ,
    output logic                  err_o
`endif
);
    typedef enum logic {WAIT_DATA, WAIT_NULL} state_e;

    state_e                 state_q;
    logic                   ack_q, valid_q;
    logic [WIDTH-1:0]       data_q, bit_set, dec;
    logic [SYNC_STAGES-1:0] comp_q, comp_d, null_q, null_d;
    logic                   comp_raw, null_raw, comp_s, null_s, slot_free;

    for (genvar g = 0; g < WIDTH; g++) begin : g_dec
        assign bit_set[g] = in[g][1] ^ in[g][0];
        assign dec[g]     = in[g][1];
    end

    assign comp_raw  = &bit_set;
    assign null_raw  = ~|in;
    assign comp_d    = {comp_q[SYNC_STAGES-2:0], comp_raw};
    assign null_d    = {null_q[SYNC_STAGES-2:0], null_raw};
    assign comp_s    = comp_q[SYNC_STAGES-1];
    assign null_s    = null_q[SYNC_STAGES-1];
    assign slot_free = !valid_q || ready_i;

    // completion/null synchronizer chains
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            comp_q <= '0;
            null_q <= '0;
        end else begin
            comp_q <= comp_d;
            null_q <= null_d;
        end
    end

    // handshake FSM: capture on synchronized completion when the slot is free, release on synchronized null
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= WAIT_DATA;
            ack_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            if (valid_q && ready_i) valid_q <= 1'b0;
            if (state_q == WAIT_DATA && comp_s && slot_free) begin
                state_q <= WAIT_NULL;
                ack_q   <= 1'b1;
                valid_q <= 1'b1;
                data_q  <= dec;
            end else if (state_q == WAIT_NULL && null_s) begin
                state_q <= WAIT_DATA;
                ack_q   <= 1'b0;
            end
        end
    end

    assign ack_o   = ack_q;
    assign valid_o = valid_q;
    assign data_o  = data_q;

`ifdef DR_SINK_ERR_EN
    logic [WIDTH-1:0]       bit_bad;
    logic [SYNC_STAGES-1:0] err_sync_q, err_sync_d;
    logic                   err_q;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bad
        assign bit_bad[g] = &in[g];
    end

    assign err_sync_d = {err_sync_q[SYNC_STAGES-2:0], |bit_bad};

    // illegal-codeword synchronizer and sticky flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_sync_q <= '0;
            err_q      <= 1'b0;
        end else begin
            err_sync_q <= err_sync_d;
            err_q      <= err_q || err_sync_q[SYNC_STAGES-1];
        end
    end

    assign err_o = err_q;
`endif
endmodule

// File: tb/tb_dr_sync_sink.sv
// tb_dr_sync_sink: directed and randomized checks of dr_sync_sink (WIDTH=4, SYNC_STAGES=2) against a word-queue model
module tb_dr_sync_sink;
    localparam int W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [W-1:0][1:0] din = '0;
    logic              ready = 1'b0;
    logic              ack, valid;
    logic [W-1:0]      data;
`ifdef DR_SINK_ERR_EN
    logic              err;
`endif
    int n_pass = 0;
    int n_total = 0;

    dr_sync_sink #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .in(din),
        .ack_o(ack),
        .data_o(data),
        .valid_o(valid),
        .ready_i(ready)
`ifdef DR_SINK_ERR_EN
        ,
        .err_o(err)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0][1:0] enc(input logic [W-1:0] w);
        logic [W-1:0][1:0] r;
        for (int i = 0; i < W; i++) r[i] = w[i] ? 2'b10 : 2'b01;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input logic v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            if (ack === v) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        din = '0;
        ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (ack !== 1'b0) $display("FAIL reset_ack got %b want 0", ack); else n_pass++;
        n_total++; if (valid !== 1'b0) $display("FAIL reset_valid got %b want 0", valid); else n_pass++;
        n_total++; if (data !== 4'h0) $display("FAIL reset_data got %h want 0", data); else n_pass++;
        rst_n = 1'b1;
        repeat (3) tick();
        n_total++; if (ack !== 1'b0 || valid !== 1'b0) $display("FAIL idle_after_reset ack=%b valid=%b want 0/0", ack, valid); else n_pass++;
    endtask

    task automatic test_latency();
        logic [W-1:0] w;
        bit ok;
        w = 4'($urandom_range(0, 15));
        ready = 1'b0;
        din = enc(w);
        for (int e = 1; e <= 3; e++) begin
            tick();
            if (e < 3) begin
                n_total++; if (valid !== 1'b0 || ack !== 1'b0) $display("FAIL latency_early edge=%0d valid=%b ack=%b want 0/0", e, valid, ack); else n_pass++;
            end else begin
                n_total++; if (valid !== 1'b1 || ack !== 1'b1) $display("FAIL latency_rise valid=%b ack=%b want 1/1", valid, ack); else n_pass++;
                n_total++; if (data !== w) $display("FAIL latency_data got %h want %h", data, w); else n_pass++;
            end
        end
        din = '0;
        ready = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            n_total++; if (valid !== 1'b0) $display("FAIL consume edge=%0d valid=%b want 0", e, valid); else n_pass++;
            n_total++; if (ack !== (e < 3)) $display("FAIL null_release edge=%0d ack=%b want %b", e, ack, e < 3); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        ready = 1'b0;
        din = enc(4'hA);
        wait_ack(1'b1, ok);
        n_total++; if (!ok) $display("FAIL bp_first_ack timeout ack=%b want 1", ack); else n_pass++;
        din = '0;
        wait_ack(1'b0, ok);
        n_total++; if (!ok) $display("FAIL bp_first_null timeout ack=%b want 0", ack); else n_pass++;
        din = enc(4'h5);
        repeat (8) begin
            tick();
            n_total++; if (ack !== 1'b0 || valid !== 1'b1 || data !== 4'hA) $display("FAIL bp_stall ack=%b valid=%b data=%h want 0/1/a", ack, valid, data); else n_pass++;
        end
        ready = 1'b1;
        tick();
        n_total++; if (ack !== 1'b1 || valid !== 1'b1 || data !== 4'h5) $display("FAIL bp_same_edge ack=%b valid=%b data=%h want 1/1/5", ack, valid, data); else n_pass++;
        tick();
        n_total++; if (valid !== 1'b0) $display("FAIL bp_drain valid=%b want 0", valid); else n_pass++;
        din = '0;
        wait_ack(1'b0, ok);
        n_total++; if (!ok) $display("FAIL bp_final_null timeout ack=%b want 0", ack); else n_pass++;
    endtask

    task automatic test_staggered();
        logic [W-1:0] w;
        w = 4'($urandom_range(0, 15));
        ready = 1'b1;
        repeat (3) tick();
        for (int t = 0; t <= 5; t++) begin
            if (t == 0) din[0] = enc(w)[0];
            if (t == 2) din[1] = enc(w)[1];
            if (t == 4) din[2] = enc(w)[2];
            if (t == 5) din[3] = enc(w)[3];
            if (t < 5) begin
                tick();
                n_total++; if (valid !== 1'b0 || ack !== 1'b0) $display("FAIL stagger_partial t=%0d valid=%b ack=%b want 0/0", t, valid, ack); else n_pass++;
            end
        end
        for (int e = 1; e <= 3; e++) begin
            tick();
            n_total++; if (valid !== (e == 3)) $display("FAIL stagger_rise edge=%0d valid=%b want %b", e, valid, e == 3); else n_pass++;
        end
        n_total++; if (data !== w) $display("FAIL stagger_data got %h want %h", data, w); else n_pass++;
        din = '0;
        repeat (5) tick();
        n_total++; if (ack !== 1'b0 || valid !== 1'b0) $display("FAIL stagger_end ack=%b valid=%b want 0/0", ack, valid); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] w;
        bit ok;
        w = 4'($urandom_range(0, 15));
        ready = 1'b0;
        din = enc(w);
        wait_ack(1'b1, ok);
        n_total++; if (!ok) $display("FAIL rmid_ack timeout ack=%b want 1", ack); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (ack !== 1'b0 || valid !== 1'b0 || data !== 4'h0) $display("FAIL rmid_async ack=%b valid=%b data=%h want 0/0/0", ack, valid, data); else n_pass++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            n_total++; if (valid !== (e == 3) || ack !== (e == 3)) $display("FAIL rmid_recapture edge=%0d valid=%b ack=%b want %b", e, valid, ack, e == 3); else n_pass++;
        end
        n_total++; if (data !== w) $display("FAIL rmid_data got %h want %h", data, w); else n_pass++;
        din = '0;
        ready = 1'b1;
        wait_ack(1'b0, ok);
        n_total++; if (!ok) $display("FAIL rmid_null timeout ack=%b want 0", ack); else n_pass++;
        tick();
    endtask

    // upstream source runs a 4-phase handshake; model is the ordered queue of words it sent
    task automatic test_stream(input bit rnd, input int cycles);
        logic [W-1:0] q[$];
        logic [W-1:0] w, exp_w, pdata;
        int sp, dly, got;
        bit hs, pstall;
        sp = 0;
        dly = 0;
        got = 0;
        pstall = 1'b0;
        pdata = '0;
        ready = 1'b1;
        for (int c = 0; c < cycles + 400; c++) begin
            if (c >= cycles && sp == 0 && q.size() == 0) break;
            if (pstall) begin
                n_total++; if (valid !== 1'b1 || data !== pdata) $display("FAIL stream_hold valid=%b data=%h want 1/%h", valid, data, pdata); else n_pass++;
            end
            case (sp)
                0: if (c < cycles) begin
                    if (dly == 0) begin
                        w = rnd ? 4'($urandom_range(0, 15)) : 4'hA;
                        din = enc(w);
                        q.push_back(w);
                        sp = 1;
                    end else dly--;
                end
                1: if (ack) begin
                    din = '0;
                    sp = 2;
                end
                default: if (!ack) begin
                    sp = 0;
                    dly = rnd ? $urandom_range(0, 3) : 0;
                end
            endcase
            ready = (rnd && c < cycles) ? 1'($urandom_range(0, 1)) : 1'b1;
            hs = valid && ready;
            pstall = valid && !ready;
            pdata = data;
            if (hs) begin
                got++;
                if (q.size() == 0) begin
                    n_total++; $display("FAIL stream_dup got %h want none", data);
                end else begin
                    exp_w = q.pop_front();
                    n_total++; if (data !== exp_w) $display("FAIL stream_word got %h want %h", data, exp_w); else n_pass++;
                end
            end
            tick();
        end
        n_total++; if (q.size() != 0 || got == 0) $display("FAIL stream_drain pending=%0d received=%0d want 0/>0", q.size(), got); else n_pass++;
        repeat (4) tick();
        n_total++; if (valid !== 1'b0) $display("FAIL stream_extra valid=%b want 0", valid); else n_pass++;
    endtask

`ifdef DR_SINK_ERR_EN
    task automatic test_err();
        bit seen;
        ready = 1'b1;
        n_total++; if (err !== 1'b0) $display("FAIL err_init got %b want 0", err); else n_pass++;
        din = enc(4'h3);
        din[2] = 2'b11;
        tick();
        din = '0;
        seen = 1'b0;
        for (int e = 0; e < 3 && !seen; e++) begin
            tick();
            seen = (err === 1'b1);
        end
        n_total++; if (!seen) $display("FAIL err_set got %b want 1", err); else n_pass++;
        repeat (10) tick();
        n_total++; if (err !== 1'b1 || valid !== 1'b0 || ack !== 1'b0) $display("FAIL err_hold err=%b valid=%b ack=%b want 1/0/0", err, valid, ack); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (err !== 1'b0) $display("FAIL err_reset got %b want 0", err); else n_pass++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_backpressure();
        test_staggered();
        test_reset_mid();
        test_stream(1'b0, 200);
        test_stream(1'b1, 2000);
`ifdef DR_SINK_ERR_EN
        test_err();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
